// File: rtl/data_memory_lsu_if.sv
// Request/response bus between a requester and the data memory LSU.
// Handshake rules, identical on both channels: a transfer happens on a rising
// clk edge where valid && ready are both 1. The driving side holds valid and
// its payload stable until that edge. The receiving side may raise or drop
// ready freely, and ready never depends combinationally on valid.
interface data_memory_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_memory_lsu.sv
// Single-outstanding load/store unit in front of a byte-lane-writable word
// memory. It handles one request at a time, inserts optional wait states, and
// sign- or zero-extends load data.
// Optional feature: define DATA_MEMORY_LSU_MISALIGN_SPLIT_EN to split
// misaligned half/word accesses into two row accesses. When the macro is not
// defined, a misaligned access returns rsp_err.
module data_memory_lsu #(
   parameter int DEPTH_BYTES = 2048,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   data_memory_lsu_if.slave  bus,
   output logic [1:0]        dbg_state
);
   localparam int ROWS = DEPTH_BYTES / 4;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACCESS2 = 2'd2, RESP = 2'd3} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic        we_q, uns_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] lo_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        accept, do_access, do_access2;

   logic [31:0] mem [ROWS];

   logic [2:0]  nbytes;
   logic [3:0]  be_base;
   logic [1:0]  off;
   logic [7:0]  be64;
   logic [63:0] wd64, rd64, rd_sh;
   logic [32:0] last_byte;
   logic        size_bad, misalign, range_bad, err_c, split_c;
   logic [RW-1:0] row_lo, row_hi;
   logic [31:0] load_data;

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                          input logic uns);
      case (sz)
         2'b00:   extend = uns ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   extend = uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: extend = d;
      endcase
   endfunction

   // Decode the latched request: lanes, range, alignment, and load data.
   always_comb begin
      nbytes  = 3'd1;
      be_base = 4'b0001;
      case (size_q)
         2'b01:   begin nbytes = 3'd2; be_base = 4'b0011; end
         2'b10:   begin nbytes = 3'd4; be_base = 4'b1111; end
         default: begin nbytes = 3'd1; be_base = 4'b0001; end
      endcase
      off       = addr_q[1:0];
      size_bad  = (size_q == 2'b11);
      misalign  = ((size_q == 2'b01) && addr_q[0]) ||
                  ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
      last_byte = {1'b0, addr_q} + {30'b0, nbytes} - 33'd1;
      range_bad = (last_byte >= 33'(DEPTH_BYTES));
`ifdef DATA_MEMORY_LSU_MISALIGN_SPLIT_EN
      // A split access also needs the following row to exist.
      err_c   = size_bad || range_bad ||
                (misalign && (({1'b0, addr_q[31:2]} + 31'd1) >= 31'(ROWS)));
      split_c = misalign;
`else
      err_c   = size_bad || range_bad || misalign;
      split_c = 1'b0;
`endif
      row_lo    = addr_q[RW+1:2];
      row_hi    = row_lo + 1'b1;
      be64      = {4'b0, be_base} << off;
      wd64      = {32'b0, wdata_q} << {off, 3'b000};
      rd64      = (state == ACCESS2) ? {mem[row_hi], lo_q} : {32'b0, mem[row_lo]};
      rd_sh     = rd64 >> {off, 3'b000};
      load_data = extend(rd_sh[31:0], size_q, uns_q);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      do_access  = 1'b0;
      do_access2 = 1'b0;
      case (state)
         IDLE: begin
            accept = bus.req_valid;
            if (bus.req_valid) state_nx = ACCESS;
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               do_access = 1'b1;
               state_nx  = (split_c && !err_c) ? ACCESS2 : RESP;
            end
         end
         ACCESS2: begin
            do_access2 = 1'b1;
            state_nx   = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign dbg_state     = state;

   // Request latch, wait counter, and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         lo_q    <= 32'b0;
         rdata_q <= 32'b0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt     <= 4'(WAIT_CYCLES);
         end
         if ((state == ACCESS) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
         if (do_access) begin
            if (err_c) begin
               rdata_q <= 32'b0;
               err_q   <= 1'b1;
            end else begin
               err_q   <= 1'b0;
               lo_q    <= mem[row_lo];
               rdata_q <= we_q ? 32'b0 : load_data;
            end
         end
         if (do_access2) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'b0 : load_data;
         end
      end
   end

   // Byte-lane writes. The low row is written in ACCESS and the next row in ACCESS2.
   always_ff @(posedge clk) begin
      if (do_access && we_q && !err_c) begin
         for (int i = 0; i < 4; i++)
            if (be64[i]) mem[row_lo][8*i +: 8] <= wd64[8*i +: 8];
      end
      if (do_access2 && we_q) begin
         for (int i = 0; i < 4; i++)
            if (be64[4+i]) mem[row_hi][8*i +: 8] <= wd64[32+8*i +: 8];
      end
   end
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu. It uses three units that share one clock
// and one reset, with wait states 0, 3 and 2.
module tb_data_memory_lsu;
   logic        clk;
   logic        rst;
   logic        v_d   [3];
   logic        we_d  [3];
   logic [1:0]  sz_d  [3];
   logic        un_d  [3];
   logic [31:0] ad_d  [3];
   logic [31:0] wd_d  [3];
   logic        rr    [3];
   logic        rdy   [3];
   logic        rv    [3];
   logic [31:0] rd    [3];
   logic        er    [3];
   logic [1:0]  st    [3];

   int n_chk;
   int n_pass;

   for (genvar g = 0; g < 3; g++) begin : g_unit
      localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
      data_memory_lsu_if bus ();
      assign bus.req_valid    = v_d[g];
      assign bus.req_we       = we_d[g];
      assign bus.req_size     = sz_d[g];
      assign bus.req_unsigned = un_d[g];
      assign bus.req_addr     = ad_d[g];
      assign bus.req_wdata    = wd_d[g];
      assign bus.rsp_ready    = rr[g];
      assign rdy[g]           = bus.req_ready;
      assign rv[g]            = bus.rsp_valid;
      assign rd[g]            = bus.rsp_rdata;
      assign er[g]            = bus.rsp_err;
      data_memory_lsu #(.DEPTH_BYTES(2048), .WAIT_CYCLES(WC)) dut (
         .clk       (clk),
         .rst       (rst),
         .bus       (bus),
         .dbg_state (st[g])
      );
   end

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drives one request, waits for the response and consumes it (rsp_ready is already 1).
   task automatic xfer(input int u, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err, output int lat);
      int k;
      @(negedge clk);
      v_d[u] = 1'b1; we_d[u] = we; sz_d[u] = sz; un_d[u] = uns; ad_d[u] = addr; wd_d[u] = wd;
      k = 0;
      while (!rdy[u] && k < 50) begin @(negedge clk); k++; end
      chk("req_ready_wait", {31'b0, rdy[u]}, 32'd1);
      @(posedge clk); #1;
      v_d[u] = 1'b0;
      lat = 0;
      while (!rv[u] && lat < 100) begin @(posedge clk); #1; lat++; end
      rdata = rd[u];
      err   = er[u];
      @(posedge clk); #1;
   endtask

   logic [31:0] r, r0, exp_r0, exp_r4, exp_r2, exp_e2;
   logic        e;
   int          lat, bad, exp_lat;

   initial begin
      n_chk = 0; n_pass = 0;
      for (int i = 0; i < 3; i++) begin
         v_d[i] = 0; we_d[i] = 0; sz_d[i] = 0; un_d[i] = 0; ad_d[i] = 0; wd_d[i] = 0; rr[i] = 1;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("reset_req_ready", {31'b0, rdy[0]}, 32'd1);
      chk("reset_rsp_valid", {31'b0, rv[0]}, 32'd0);
      chk("reset_rsp_rdata", rd[0], 32'd0);
      chk("reset_rsp_err",   {31'b0, er[0]}, 32'd0);

      // Store a word, then load it back, with no wait states.
      xfer(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, r, e, lat);
      chk("st_word_lat", 32'(lat), 32'd1);
      chk("st_word_rdata", r, 32'd0);
      chk("st_word_err", {31'b0, e}, 32'd0);
      xfer(0, 0, 2'b10, 0, 32'h10, 32'h0, r, e, lat);
      chk("ld_word_lat", 32'(lat), 32'd1);
      chk("ld_word_rdata", r, 32'hDEADBEEF);
      chk("ld_word_err", {31'b0, e}, 32'd0);

      // Byte and half lanes, with sign and zero extension.
      xfer(0, 1, 2'b10, 0, 32'h10, 32'h0, r, e, lat);
      xfer(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFF80, r, e, lat);
      xfer(0, 0, 2'b00, 0, 32'h11, 32'h0, r, e, lat);
      chk("ld_byte_signed", r, 32'hFFFFFF80);
      xfer(0, 0, 2'b00, 1, 32'h11, 32'h0, r, e, lat);
      chk("ld_byte_unsigned", r, 32'h00000080);
      xfer(0, 0, 2'b10, 1, 32'h10, 32'h0, r, e, lat);
      chk("ld_word_after_byte", r, 32'h00008000);
      xfer(0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, r, e, lat);
      xfer(0, 0, 2'b10, 0, 32'h10, 32'h0, r, e, lat);
      chk("ld_word_after_half", r, 32'hBEEF8000);
      xfer(0, 0, 2'b01, 0, 32'h12, 32'h0, r, e, lat);
      chk("ld_half_signed", r, 32'hFFFFBEEF);
      xfer(0, 0, 2'b01, 1, 32'h12, 32'h0, r, e, lat);
      chk("ld_half_unsigned", r, 32'h0000BEEF);

      // Out-of-range and reserved-size accesses.
      xfer(0, 1, 2'b10, 0, 32'h0, 32'hA5A5A5A5, r, e, lat);
      xfer(0, 1, 2'b10, 0, 32'd2048, 32'hFFFFFFFF, r, e, lat);
      chk("oor_store_err", {31'b0, e}, 32'd1);
      chk("oor_store_rdata", r, 32'd0);
      xfer(0, 1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, r, e, lat);
      chk("size11_err", {31'b0, e}, 32'd1);
      chk("size11_rdata", r, 32'd0);
      xfer(0, 0, 2'b10, 0, 32'h0, 32'h0, r, e, lat);
      chk("mem_unchanged_row0", r, 32'hA5A5A5A5);
      xfer(0, 0, 2'b01, 0, 32'd2047, 32'h0, r, e, lat);
      chk("half_past_end_err", {31'b0, e}, 32'd1);
      xfer(0, 0, 2'b00, 0, 32'd2047, 32'h0, r, e, lat);
      chk("last_byte_in_range", {31'b0, e}, 32'd0);

      // A misaligned word store.
`ifdef DATA_MEMORY_LSU_MISALIGN_SPLIT_EN
      exp_e2 = 32'd0; exp_lat = 2; exp_r0 = 32'h33440000; exp_r4 = 32'h00001122; exp_r2 = 32'h11223344;
`else
      exp_e2 = 32'd1; exp_lat = 1; exp_r0 = 32'h0; exp_r4 = 32'h0; exp_r2 = 32'h0;
`endif
      xfer(0, 1, 2'b10, 0, 32'h0, 32'h0, r, e, lat);
      xfer(0, 1, 2'b10, 0, 32'h4, 32'h0, r, e, lat);
      xfer(0, 1, 2'b10, 0, 32'h2, 32'h11223344, r, e, lat);
      chk("misalign_st_err", {31'b0, e}, exp_e2);
      chk("misalign_st_lat", 32'(lat), 32'(exp_lat));
      xfer(0, 0, 2'b10, 0, 32'h0, 32'h0, r, e, lat);
      chk("misalign_row0", r, exp_r0);
      xfer(0, 0, 2'b10, 0, 32'h4, 32'h0, r, e, lat);
      chk("misalign_row1", r, exp_r4);
      xfer(0, 0, 2'b10, 0, 32'h2, 32'h0, r, e, lat);
      chk("misalign_ld_rdata", r, exp_r2);
      chk("misalign_ld_err", {31'b0, e}, exp_e2);

      // Three wait states with a stalled consumer. A second request is offered but ignored.
      xfer(1, 1, 2'b10, 0, 32'h40, 32'h0BADF00D, r, e, lat);
      chk("w3_store_lat", 32'(lat), 32'd4);
      rr[1] = 1'b0;
      @(negedge clk);
      v_d[1] = 1; we_d[1] = 0; sz_d[1] = 2'b10; un_d[1] = 0; ad_d[1] = 32'h40; wd_d[1] = 0;
      @(posedge clk); #1;
      we_d[1] = 1; wd_d[1] = 32'h55555555;
      lat = 0;
      while (!rv[1] && lat < 100) begin
         chk("w3_busy_ready", {31'b0, rdy[1]}, 32'd0);
         @(posedge clk); #1; lat++;
      end
      chk("w3_load_lat", 32'(lat), 32'd4);
      r0 = rd[1];
      chk("w3_load_rdata", r0, 32'h0BADF00D);
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (!rv[1] || rd[1] !== r0 || er[1] !== 1'b0 || rdy[1] !== 1'b0) bad++;
      end
      chk("w3_held_stable", 32'(bad), 32'd0);
      @(negedge clk);
      v_d[1] = 0; we_d[1] = 0; rr[1] = 1'b1;
      @(posedge clk); #1;
      chk("w3_after_hs_valid", {31'b0, rv[1]}, 32'd0);
      chk("w3_after_hs_ready", {31'b0, rdy[1]}, 32'd1);
      xfer(1, 0, 2'b10, 0, 32'h40, 32'h0, r, e, lat);
      chk("w3_ignored_store", r, 32'h0BADF00D);

      // Reset arrives while a store is waiting in ACCESS.
      xfer(2, 1, 2'b10, 0, 32'h20, 32'h12345678, r, e, lat);
      chk("w2_store_lat", 32'(lat), 32'd3);
      @(negedge clk);
      v_d[2] = 1; we_d[2] = 1; sz_d[2] = 2'b10; un_d[2] = 0; ad_d[2] = 32'h20; wd_d[2] = 32'hCAFEBABE;
      @(posedge clk); #1;
      v_d[2] = 0;
      chk("w2_in_access", {30'b0, st[2]}, 32'd1);
      #2 rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      chk("rst_drop_ready", {31'b0, rdy[2]}, 32'd1);
      chk("rst_drop_valid", {31'b0, rv[2]}, 32'd0);
      bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rv[2] !== 1'b0) bad++;
      end
      chk("rst_drop_no_rsp", 32'(bad), 32'd0);
      xfer(2, 0, 2'b10, 0, 32'h20, 32'h0, r, e, lat);
      chk("rst_drop_no_write", r, 32'h12345678);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed %0d/%0d", n_pass, n_chk);
      $fatal(1, "timeout");
   end
endmodule
